// File: rtl/lsu_ctrl.sv
// Load/store sequencer: decodes memory opcodes, runs one handshaked dmem transaction
// per instruction while stalling the core, and aligns/extends load data.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        instr_valid_i,
    input  logic [5:0]  instr_opcode_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    output logic        dmem_req_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_we_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] ld_data_o,
    output logic        ld_valid_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [2:0]       f3_q, f3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ld_data_q, ld_data_d;
    logic [1:0]       err_code_q, err_code_d;

    // Incoming instruction decode (only meaningful while IDLE).
    logic       mem_op;
    logic       in_store;
    logic [2:0] in_f3;
    logic       in_illegal;
    logic       in_misaligned;

    // Gating with rst_n_i keeps stall_o low while reset is held.
    assign mem_op   = rst_n_i & instr_valid_i & instr_opcode_i[5] & ~instr_opcode_i[4];
    assign in_store = instr_opcode_i[3];
    assign in_f3    = instr_opcode_i[2:0];

    always_comb begin
        in_illegal = 1'b1;
        if (in_store) begin
            case (in_f3)
                3'b000, 3'b001, 3'b010: in_illegal = 1'b0;
                default:                in_illegal = 1'b1;
            endcase
        end else begin
            case (in_f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: in_illegal = 1'b0;
                default:                                in_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (in_f3[1:0])
            2'b01:   in_misaligned = daddr_i[0];
            2'b10:   in_misaligned = (daddr_i[1:0] != 2'b00);
            default: in_misaligned = 1'b0;
        endcase
    end

    // Store lane placement from the latched access.
    logic [3:0]  st_we;
    logic [31:0] st_wdata;

    always_comb begin
        st_we    = 4'b0000;
        st_wdata = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                st_we    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_we    = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_we    = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

    // Load lane extraction and extension from the latched offset.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = dmem_rdata_i[7:0];
            2'b01:   ld_byte = dmem_rdata_i[15:8];
            2'b10:   ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h000000, ld_byte};
            3'b101:  ld_ext = {16'h0000, ld_half};
            default: ld_ext = dmem_rdata_i;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        ld_data_d    = ld_data_q;
        err_code_d   = err_code_q;
        dmem_req_o   = 1'b0;
        dmem_addr_o  = 32'h0000_0000;
        dmem_we_o    = 4'b0000;
        dmem_wdata_o = 32'h0000_0000;
        stall_o      = 1'b0;
        ld_valid_o   = 1'b0;
        err_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    stall_o    = 1'b1;
                    is_store_d = in_store;
                    f3_d       = in_f3;
                    addr_d     = daddr_i;
                    wdata_d    = dwdata_i;
                    cnt_d      = '0;
                    if (in_illegal) begin
                        err_code_d = CODE_ILLEGAL;
                        state_d    = S_ERR;
                    end else if (in_misaligned) begin
                        err_code_d = CODE_MISALIGN;
                        state_d    = S_ERR;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                dmem_req_o   = 1'b1;
                dmem_addr_o  = {addr_q[31:2], 2'b00};
                dmem_we_o    = is_store_q ? st_we : 4'b0000;
                dmem_wdata_o = st_wdata;
                stall_o      = 1'b1;
                cnt_d        = cnt_q + 1'b1;
                // Ack takes priority over an expiring timeout in the same cycle.
                if (dmem_ack_i) begin
                    if (!is_store_q) begin
                        ld_data_d = ld_ext;
                    end
                    state_d = S_DONE;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST)) begin
                    err_code_d = CODE_TIMEOUT;
                    state_d    = S_ERR;
                end
            end
            S_DONE: begin
                ld_valid_o = ~is_store_q;
                state_d    = S_IDLE;
            end
            S_ERR: begin
                err_o   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            cnt_q      <= '0;
            ld_data_q  <= 32'h0000_0000;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            ld_data_q  <= ld_data_d;
            err_code_q <= err_code_d;
        end
    end

    assign ld_data_o  = ld_data_q;
    assign err_code_o = err_code_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: table of transactions with expected bus/lane/result values,
// a load-result scoreboard, random aligned traffic, and reset/stray-ack sequences.
module tb_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic [5:0]  instr_opcode_i = 6'h00;
    logic [31:0] daddr_i = 32'h0;
    logic [31:0] dwdata_i = 32'h0;
    logic        dmem_req_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_we_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'h0;
    logic        stall_o;
    logic [31:0] ld_data_o;
    logic        ld_valid_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic        busy_o;

    lsu_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_valid_i(instr_valid_i),
        .instr_opcode_i(instr_opcode_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i),
        .dmem_req_o(dmem_req_o), .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .ld_data_o(ld_data_o), .ld_valid_o(ld_valid_o),
        .err_o(err_o), .err_code_o(err_code_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int K_LOAD = 0, K_STORE = 1, K_ERR = 2, K_NONMEM = 3, K_TIMEOUT = 4;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          wait_n;
        logic [31:0] e_addr;
        logic [3:0]  e_we;
        logic [31:0] e_wdata;
        logic        chk_wd;
        logic [31:0] e_ld;
        int          e_req;
        int          e_stall;
        logic        e_ldv;
        logic        e_err;
        logic [1:0]  e_code;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_ld = 32'h0;
    logic [1:0]  sticky_code = 2'b00;
    vec_t        tbl[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int kind, input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input int wait_n,
                                input logic [3:0] we, input logic [31:0] ewd,
                                input logic [31:0] eld, input logic [1:0] code);
        vec_t v;
        v.op = op; v.addr = addr; v.wd = wd; v.rd = rd; v.wait_n = wait_n;
        v.e_addr = {addr[31:2], 2'b00}; v.e_we = we; v.e_wdata = ewd;
        v.chk_wd = (kind == K_STORE); v.e_ld = eld;
        v.e_ldv = (kind == K_LOAD);
        v.e_err = (kind == K_ERR) || (kind == K_TIMEOUT);
        v.e_code = (kind == K_TIMEOUT) ? 2'b10 : code;
        case (kind)
            K_LOAD, K_STORE: begin v.e_req = wait_n + 1; v.e_stall = wait_n + 2; end
            K_ERR:           begin v.e_req = 0; v.e_stall = 1; end
            K_TIMEOUT:       begin v.e_req = 15; v.e_stall = 16; v.wait_n = 1000; end
            default:         begin v.e_req = 0; v.e_stall = 0; end
        endcase
        return v;
    endfunction

    // Reference load extraction, written from the lane description.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> (8 * off);
        b = sh[7:0];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic run_op(input string tag, input vec_t v);
        int   req_n, stall_n, ldv_n, err_n;
        logic lane_bad, fin;
        logic [1:0] code_seen;
        req_n = 0; stall_n = 0; ldv_n = 0; err_n = 0;
        lane_bad = 1'b0; fin = 1'b0; code_seen = 2'b00;
        @(posedge clk_i); #1;
        instr_valid_i = 1'b1; instr_opcode_i = v.op; daddr_i = v.addr;
        dwdata_i = v.wd; dmem_rdata_i = v.rd;
        if (v.e_ldv) exp_q.push_back(v.e_ld);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_i);
            if (dmem_req_o) begin
                req_n++;
                if (dmem_addr_o !== v.e_addr || dmem_we_o !== v.e_we ||
                    (v.chk_wd && dmem_wdata_o !== v.e_wdata)) lane_bad = 1'b1;
                if (req_n == v.wait_n + 1) dmem_ack_i = 1'b1;
            end
            if (stall_o) stall_n++;
            if (ld_valid_o) begin
                ldv_n++;
                if (exp_q.size() == 0) check({tag, " ld_unexpected"}, 32'd1, 32'd0);
                else check({tag, " ld_data"}, ld_data_o, exp_q.pop_front());
            end
            if (err_o) begin err_n++; code_seen = err_code_o; end
            if (!stall_o) begin fin = 1'b1; break; end
            @(posedge clk_i); #1;
            dmem_ack_i = 1'b0;
        end
        instr_valid_i = 1'b0;
        dmem_ack_i = 1'b0;
        check({tag, " finished_in_budget"}, {31'h0, fin}, 32'd1);
        check({tag, " req_cycles"}, req_n, v.e_req);
        check({tag, " stall_cycles"}, stall_n, v.e_stall);
        check({tag, " ld_valid_pulses"}, ldv_n, {31'h0, v.e_ldv});
        check({tag, " err_pulses"}, err_n, {31'h0, v.e_err});
        if (v.e_err) check({tag, " err_code"}, {30'h0, code_seen}, {30'h0, v.e_code});
        if (v.e_req > 0) check({tag, " lanes_stable"}, {31'h0, lane_bad}, 32'd0);
        if (v.e_ldv) last_ld = v.e_ld;
        if (v.e_err) sticky_code = v.e_code;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check({tag, " idle_after"}, {30'h0, busy_o, stall_o}, 32'd0);
        check({tag, " ld_data_held"}, ld_data_o, last_ld);
        check({tag, " err_code_held"}, {30'h0, err_code_o}, {30'h0, sticky_code});
        if (exp_q.size() != 0) begin
            check({tag, " scoreboard_drained"}, exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        // Test-plan rows and lane/extension corners.
        tbl[0]  = mk(K_LOAD,  6'b100_000, 32'h103, 32'h0, 32'h80FF_1234, 0, 4'b0000, 32'h0, 32'hFFFF_FF80, 2'b00);
        tbl[1]  = mk(K_STORE, 6'b101_001, 32'h202, 32'hDEAD_BEEF, 32'h0, 3, 4'b1100, 32'hBEEF_BEEF, 32'h0, 2'b00);
        tbl[2]  = mk(K_ERR,   6'b100_101, 32'h001, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 2'b01);
        tbl[3]  = mk(K_ERR,   6'b100_010, 32'h006, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 2'b01);
        tbl[4]  = mk(K_ERR,   6'b100_011, 32'h000, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 2'b11);
        tbl[5]  = mk(K_ERR,   6'b101_100, 32'h000, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 2'b11);
        tbl[6]  = mk(K_TIMEOUT, 6'b100_010, 32'h040, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 2'b10);
        tbl[7]  = mk(K_LOAD,  6'b100_100, 32'h102, 32'h0, 32'h80FF_1234, 1, 4'b0000, 32'h0, 32'h0000_00FF, 2'b00);
        tbl[8]  = mk(K_LOAD,  6'b100_001, 32'h102, 32'h0, 32'h80FF_1234, 0, 4'b0000, 32'h0, 32'hFFFF_80FF, 2'b00);
        tbl[9]  = mk(K_LOAD,  6'b100_001, 32'h100, 32'h0, 32'h1234_ABCD, 2, 4'b0000, 32'h0, 32'hFFFF_ABCD, 2'b00);
        tbl[10] = mk(K_LOAD,  6'b100_101, 32'h102, 32'h0, 32'h8765_0000, 0, 4'b0000, 32'h0, 32'h0000_8765, 2'b00);
        tbl[11] = mk(K_LOAD,  6'b100_010, 32'h104, 32'h0, 32'hCAFE_F00D, 2, 4'b0000, 32'h0, 32'hCAFE_F00D, 2'b00);
        tbl[12] = mk(K_STORE, 6'b101_000, 32'h301, 32'h1234_56A5, 32'h0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 2'b00);
        tbl[13] = mk(K_STORE, 6'b101_010, 32'h400, 32'h0123_4567, 32'h0, 1, 4'b1111, 32'h0123_4567, 32'h0, 2'b00);
        tbl[14] = mk(K_STORE, 6'b101_001, 32'h200, 32'hDEAD_BEEF, 32'h0, 0, 4'b0011, 32'hBEEF_BEEF, 32'h0, 2'b00);
        tbl[15] = mk(K_NONMEM, 6'b000_010, 32'h100, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 2'b00);
        tbl[16] = mk(K_NONMEM, 6'b110_000, 32'h100, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 2'b00);
        tbl[17] = mk(K_NONMEM, 6'b111_000, 32'h100, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 2'b00);
        // Ack on the very last allowed cycle beats the timeout.
        tbl[18] = mk(K_LOAD,  6'b100_000, 32'h083, 32'h0, 32'h7F00_0000, 14, 4'b0000, 32'h0, 32'h0000_007F, 2'b00);

        #3;
        check("reset req/stall/busy", {29'h0, dmem_req_o, stall_o, busy_o}, 32'd0);
        check("reset ld_valid/err", {30'h0, ld_valid_o, err_o}, 32'd0);
        check("reset err_code", {30'h0, err_code_o}, 32'd0);
        check("reset ld_data", ld_data_o, 32'd0);
        check("reset we/addr", {dmem_we_o, dmem_addr_o[27:0]}, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 19; i++) run_op($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  f3;
            logic [1:0]  off;
            logic [31:0] a, d, r;
            int          w;
            a = $urandom & 32'hFFFF_FFF0;
            d = $urandom;
            r = $urandom;
            w = $urandom_range(0, 3);
            if (i < 6) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
                off = (f3[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) :
                      (f3[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
                a[1:0] = off;
                run_op($sformatf("rnd_ld%0d", i),
                       mk(K_LOAD, {3'b100, f3}, a, d, r, w, 4'b0000, 32'h0,
                          model_load(f3, off, r), 2'b00));
            end else begin
                logic [3:0]  we;
                logic [31:0] wd;
                f3 = 3'($urandom_range(0, 2));
                off = (f3 == 3'd0) ? 2'($urandom_range(0, 3)) :
                      (f3 == 3'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
                a[1:0] = off;
                case (f3)
                    3'd0:    begin we = 4'b0001 << off; wd = {4{d[7:0]}}; end
                    3'd1:    begin we = off[1] ? 4'b1100 : 4'b0011; wd = {2{d[15:0]}}; end
                    default: begin we = 4'b1111; wd = d; end
                endcase
                run_op($sformatf("rnd_st%0d", i),
                       mk(K_STORE, {3'b101, f3}, a, d, r, w, we, wd, 32'h0, 2'b00));
            end
        end

        // Async reset in the middle of an ACCESS wait.
        @(posedge clk_i); #1;
        instr_valid_i = 1'b1; instr_opcode_i = 6'b100_010; daddr_i = 32'h500;
        repeat (3) @(posedge clk_i);
        #2;
        check("pre-reset in access", {31'h0, dmem_req_o}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        check("mid-reset req/stall/busy", {29'h0, dmem_req_o, stall_o, busy_o}, 32'd0);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
        @(posedge clk_i); #1;
        check("ack during reset no ld_valid", {31'h0, ld_valid_o}, 32'd0);
        dmem_ack_i = 1'b0; instr_valid_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        last_ld = 32'h0; sticky_code = 2'b00;
        check("post-reset ld_data", ld_data_o, 32'd0);
        check("post-reset err_code", {30'h0, err_code_o}, 32'd0);
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b1;
        @(negedge clk_i);
        check("stray ack idle", {29'h0, busy_o, ld_valid_o, dmem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
        @(negedge clk_i);
        check("stray ack no effect", {31'h0, ld_valid_o}, 32'd0);
        check("stray ack ld_data", ld_data_o, 32'd0);
        run_op("sw_after_reset",
               mk(K_STORE, 6'b101_010, 32'h600, 32'h89AB_CDEF, 32'h0, 0, 4'b1111,
                  32'h89AB_CDEF, 32'h0, 2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
